// File: rtl/serializer_fsm_pkg.sv
// Shared types for the serializer: FSM state encodings and counter sizing.
package serializer_fsm_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StShift  = 2'b01,
    StParity = 2'b10
  } state_e;

  // Counter must be able to hold LENGTH, so one extra code beyond LENGTH-1.
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/serializer_fsm_if.sv
// Word-in / bit-out handshake bundle between the FIR, the serializer and the serial sink.
interface serializer_fsm_if #(
  parameter int unsigned LENGTH = 24
);
  logic [LENGTH-1:0] iv_din;
  logic              i_din_valid;
  logic              o_ready;
  logic              o_dout;
  logic              o_dout_valid;
  logic              i_ready;
  logic              o_last;
  logic              o_busy;

  modport master (
    output iv_din, i_din_valid, i_ready,
    input  o_ready, o_dout, o_dout_valid, o_last, o_busy
  );

  modport slave (
    input  iv_din, i_din_valid, i_ready,
    output o_ready, o_dout, o_dout_valid, o_last, o_busy
  );
endinterface

// File: rtl/serializer_fsm_hold_buf.sv
// One-word holding register with full flag; clear has priority over load, load over pop.
module serializer_fsm_hold_buf #(
  parameter int unsigned LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_pop,
  input  logic              i_clr,
  input  logic [LENGTH-1:0] iv_din,
  output logic              o_full,
  output logic [LENGTH-1:0] ov_dout
);

  logic              full_q;
  logic [LENGTH-1:0] data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (i_clr) begin
      full_q <= 1'b0;
    end else if (i_load) begin
      full_q <= 1'b1;
      data_q <= iv_din;
    end else if (i_pop) begin
      full_q <= 1'b0;
    end
  end

  assign o_full  = full_q;
  assign ov_dout = data_q;

endmodule

// File: rtl/serializer_fsm.sv
// Parallel-to-serial output stage, LSB first, with a one-word holding buffer.
// Define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module serializer_fsm
  import serializer_fsm_pkg::*;
#(
  parameter int unsigned LENGTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  serializer_fsm_if.slave  bus
);

  localparam int unsigned       CntW    = cnt_width(LENGTH);
  localparam logic [CntW-1:0]   LastCnt = CntW'(LENGTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LENGTH-1:0] shift_q, shift_d;
  logic [LENGTH-1:0] load_word, hold_word;
  logic              hold_full, hold_push, hold_pop, hold_clr;
  logic              accept, xfer, load, frame_end;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
`ifdef SERIALIZER_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Keep o_ready low through reset so the FIR never sees a phantom accept.
  assign bus.o_ready = i_rst_n && i_en && !hold_full;
  assign accept      = bus.i_din_valid && bus.o_ready;
  assign xfer        = valid_q && bus.i_ready && i_en;

  serializer_fsm_hold_buf #(
    .LENGTH (LENGTH)
  ) u_hold_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (hold_push),
    .i_pop   (hold_pop),
    .i_clr   (hold_clr),
    .iv_din  (bus.iv_din),
    .o_full  (hold_full),
    .ov_dout (hold_word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    load_word = bus.iv_din;
    load      = 1'b0;
    frame_end = 1'b0;
    hold_push = 1'b0;
    hold_pop  = 1'b0;
    hold_clr  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      StIdle: begin
        if (accept) load = 1'b1;
      end
      StShift: begin
        if (xfer) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
`ifdef SERIALIZER_PARITY_EN
            state_d = StParity;
`else
            frame_end = 1'b1;
`endif
          end
        end
        if (accept && !frame_end) hold_push = 1'b1;
      end
`ifdef SERIALIZER_PARITY_EN
      StParity: begin
        if (xfer) frame_end = 1'b1;
        if (accept && !frame_end) hold_push = 1'b1;
      end
`endif
      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        hold_clr = i_en;
      end
    endcase

    // Back-to-back: a held word wins; else a word arriving on the closing edge goes straight in.
    if (frame_end) begin
      if (hold_full) begin
        load      = 1'b1;
        load_word = hold_word;
        hold_pop  = 1'b1;
      end else if (!accept) begin
        state_d = StIdle;
      end else begin
        load = 1'b1;
      end
    end

    if (load) begin
      state_d  = StShift;
      cnt_d    = '0;
      shift_d  = load_word;
`ifdef SERIALIZER_PARITY_EN
      parity_d = ^load_word;
`endif
    end
  end

  // Output registers follow the next state so the first bit appears right after the accept edge.
  always_comb begin
    dout_d  = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    case (state_d)
      StShift: begin
        dout_d  = shift_d[0];
        valid_d = 1'b1;
`ifndef SERIALIZER_PARITY_EN
        last_d  = (cnt_d == LastCnt);
`endif
      end
`ifdef SERIALIZER_PARITY_EN
      StParity: begin
        dout_d  = parity_d;
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      dout_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (i_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.o_dout       = dout_q;
  assign bus.o_dout_valid = valid_q;
  assign bus.o_last       = last_q;
  assign bus.o_busy       = (state_q != StIdle) || hold_full;

endmodule

// File: tb/tb_serializer_fsm.sv
// Directed bench for serializer_fsm: table of words plus back-to-back, stall, reset and enable cases.
module tb_serializer_fsm;

  localparam int unsigned LEN = 24;
`ifdef SERIALIZER_PARITY_EN
  localparam int FB = LEN + 1;
`else
  localparam int FB = LEN;
`endif

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_en    = 1'b0;

  serializer_fsm_if #(.LENGTH(LEN)) bus ();

  serializer_fsm #(
    .LENGTH (LEN)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [23:0] din;
    logic        exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected frame contents as received LSB first, parity bit included only when enabled.
  function automatic logic [63:0] exp_frame(input logic [23:0] w, input logic p);
    logic [63:0] e;
    e = {39'd0, p, w};
    return e & ((64'd1 << FB) - 64'd1);
  endfunction

  // Present a word; returns at the negedge after the accepting clock edge.
  task automatic send(input logic [LEN-1:0] w, output bit ok);
    ok = 1'b0;
    bus.iv_din      = w;
    bus.i_din_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (bus.o_ready) begin
        ok = 1'b1;
        @(negedge i_clk);
        break;
      end
      @(negedge i_clk);
    end
    bus.i_din_valid = 1'b0;
  endtask

  // Collect n transferred bits at negedges, driving i_ready from pat; flags gaps and stall changes.
  task automatic rx(input int n, input int budget, input logic [63:0] pat,
                    output logic [63:0] data, output logic [63:0] lastm,
                    output int got, output int gaps, output int viol);
    logic pd, pl, stalled;
    data = '0; lastm = '0; got = 0; gaps = 0; viol = 0;
    stalled = 1'b0; pd = 1'b0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      bus.i_ready = pat[c % 64];
      if (stalled && (!bus.o_dout_valid || bus.o_dout !== pd || bus.o_last !== pl)) viol++;
      stalled = bus.o_dout_valid && !bus.i_ready;
      pd = bus.o_dout;
      pl = bus.o_last;
      if (bus.o_dout_valid && bus.i_ready && i_en) begin
        data[got]  = bus.o_dout;
        lastm[got] = bus.o_last;
        got++;
      end else if (got > 0 && !bus.o_dout_valid) begin
        gaps++;
      end
      if (got == n) break;
      @(negedge i_clk);
    end
    bus.i_ready = 1'b1;
  endtask

  task automatic check_frame(input string name, input logic [63:0] data, input logic [63:0] lastm,
                             input int got, input int gaps, input int viol,
                             input int n, input logic [63:0] exp_d, input logic [63:0] exp_l);
    check({name, " bits"}, 64'(got), 64'(n));
    check({name, " data"}, data, exp_d);
    check({name, " last"}, lastm, exp_l);
    check({name, " gaps"}, 64'(gaps), 64'd0);
    check({name, " stall"}, 64'(viol), 64'd0);
  endtask

  task automatic check_idle(input string name);
    check({name, " idle valid"}, 64'(bus.o_dout_valid), 64'd0);
    check({name, " idle busy"}, 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, l, d2, l2;
    int got, gaps, viol, got2, lows, changes;
    bit ok, ok2;
    logic pd, pv;
    logic [63:0] lone;

    vecs[0] = '{24'hA5F00F, 1'b0};
    vecs[1] = '{24'h000001, 1'b1};
    vecs[2] = '{24'h800000, 1'b1};
    vecs[3] = '{24'hFFFFFF, 1'b0};
    vecs[4] = '{24'h5A5A5A, 1'b0};
    vecs[5] = '{24'h000000, 1'b0};
    vecs[6] = '{24'h123456, 1'b1};
    lone = 64'd1 << (FB - 1);

    bus.iv_din      = 24'h0;
    bus.i_din_valid = 1'b1;
    bus.i_ready     = 1'b1;
    i_en            = 1'b1;

    // Reset state, with a word offered to confirm nothing is accepted during reset.
    #12;
    check("rst o_ready", 64'(bus.o_ready), 64'd0);
    check("rst o_dout_valid", 64'(bus.o_dout_valid), 64'd0);
    check("rst o_dout", 64'(bus.o_dout), 64'd0);
    check("rst o_last", 64'(bus.o_last), 64'd0);
    check("rst o_busy", 64'(bus.o_busy), 64'd0);
    @(negedge i_clk);
    bus.i_din_valid = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("idle o_ready", 64'(bus.o_ready), 64'd1);
    check_idle("post-rst");

    // Table of single words, sink always ready.
    foreach (vecs[i]) begin
      send(vecs[i].din, ok);
      check($sformatf("vec%0d accept", i), 64'(ok), 64'd1);
      rx(FB, 60, '1, d, l, got, gaps, viol);
      check_frame($sformatf("vec%0d", i), d, l, got, gaps, viol, FB,
                  exp_frame(vecs[i].din, vecs[i].exp_par), lone);
      @(negedge i_clk);
      check_idle($sformatf("vec%0d", i));
    end

    // Back-to-back words through the holding buffer.
    fork
      begin
        send(24'h000001, ok);
        send(24'h800000, ok2);
        lows = 0;
        for (int c = 0; c < 100; c++) begin
          #1;
          if (bus.o_ready) break;
          lows++;
          @(negedge i_clk);
        end
      end
      rx(2 * FB, 150, '1, d, l, got, gaps, viol);
    join
    check("b2b accept1", 64'(ok), 64'd1);
    check("b2b accept2", 64'(ok2), 64'd1);
    check("b2b ready-low cycles", 64'(lows), 64'(FB - 1));
    check_frame("b2b", d, l, got, gaps, viol, 2 * FB,
                exp_frame(24'h000001, 1'b1) | (exp_frame(24'h800000, 1'b1) << FB),
                lone | (lone << FB));
    @(negedge i_clk);
    check_idle("b2b");

    // Sink stalls 1-0-0-1 twice mid-frame.
    send(24'hC3A596, ok);
    rx(FB, 80, 64'hFFFF_FFFF_FFFF_CF9F, d, l, got, gaps, viol);
    check_frame("stall", d, l, got, gaps, viol, FB, exp_frame(24'hC3A596, 1'b0), lone);
    @(negedge i_clk);
    check_idle("stall");

    // Asynchronous reset at bit 10, then a fresh word restarts at bit 0.
    send(24'hFFFFFF, ok);
    rx(10, 40, '1, d, l, got, gaps, viol);
    check("rst-mid partial", d, 64'h3FF);
    #2 i_rst_n = 1'b0;
    #1;
    check("rst-mid o_dout_valid", 64'(bus.o_dout_valid), 64'd0);
    check("rst-mid o_dout", 64'(bus.o_dout), 64'd0);
    check("rst-mid o_busy", 64'(bus.o_busy), 64'd0);
    check("rst-mid o_ready", 64'(bus.o_ready), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send(24'h0000F1, ok);
    rx(FB, 60, '1, d, l, got, gaps, viol);
    check_frame("after-rst", d, l, got, gaps, viol, FB, exp_frame(24'h0000F1, 1'b1), lone);
    @(negedge i_clk);

    // Clock enable low for five cycles mid-frame while the sink stays ready.
    send(24'h6B1D39, ok);
    rx(8, 40, '1, d, l, got, gaps, viol);
    @(negedge i_clk);
    i_en = 1'b0;
    pd = bus.o_dout;
    pv = bus.o_dout_valid;
    #1;
    check("en-low o_ready", 64'(bus.o_ready), 64'd0);
    changes = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (bus.o_dout !== pd || bus.o_dout_valid !== pv || bus.o_busy !== 1'b1) changes++;
    end
    check("en-low frozen", 64'(changes), 64'd0);
    i_en = 1'b1;
    rx(FB - 8, 60, '1, d2, l2, got2, gaps, viol);
    check_frame("en-low", d | (d2 << 8), l | (l2 << 8), got + got2, gaps, viol, FB,
                exp_frame(24'h6B1D39, 1'b1), lone);
    @(negedge i_clk);
    check_idle("en-low");

`ifdef SERIALIZER_PARITY_EN
    send(24'h000007, ok);
    rx(FB, 60, '1, d, l, got, gaps, viol);
    check_frame("parity", d, l, got, gaps, viol, FB, 64'h100_0007, 64'h100_0000);
    @(negedge i_clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
